// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Round-robin arbiter that lets two requesters share one single-port RAM.
// One transaction at a time is outstanding at the RAM; every output is registered.
// Optional build macro: RAM_ARB_TIMEOUT_EN adds a BUSY watchdog, the TIMEOUT_CYCLES
// parameter and the timeout_err output. Without it BUSY waits for mem_ready forever.
//
// state  | meaning
// S_IDLE | no owner; sample r0_valid/r1_valid and grant one of them
// S_BUSY | request latched onto mem_*, waiting for mem_ready (or the watchdog)
// S_RESP | one-cycle ready pulse to the owner, then release the grant

module ram_port_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
`ifdef RAM_ARB_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = 16
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  r0_valid,
   input  logic                  r0_wr_rd,
   input  logic [ADDR_WIDTH-1:0] r0_addr,
   input  logic [DATA_WIDTH-1:0] r0_din,
   output logic                  r0_ready,
   output logic [DATA_WIDTH-1:0] r0_dout,
   input  logic                  r1_valid,
   input  logic                  r1_wr_rd,
   input  logic [ADDR_WIDTH-1:0] r1_addr,
   input  logic [DATA_WIDTH-1:0] r1_din,
   output logic                  r1_ready,
   output logic [DATA_WIDTH-1:0] r1_dout,
   output logic                  mem_valid,
   output logic                  mem_wr_rd,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_din,
   input  logic                  mem_ready,
   input  logic [DATA_WIDTH-1:0] mem_dout,
   output logic [1:0]            grant
`ifdef RAM_ARB_TIMEOUT_EN
   , output logic                timeout_err
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_last_grant;   // 0 = req0 served last, 1 = req1
   logic                  r_owner;        // requester currently holding the RAM
   logic                  r_r0_ready;
   logic                  r_r1_ready;
   logic [DATA_WIDTH-1:0] r_r0_dout;
   logic [DATA_WIDTH-1:0] r_r1_dout;
   logic                  r_mem_valid;
   logic                  r_mem_wr_rd;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [DATA_WIDTH-1:0] r_mem_din;
   logic [1:0]            r_grant;
   logic                  w_gnt0;
   logic                  w_gnt1;
   logic                  w_timeout;
   logic                  w_done;

   // req0 wins unless req1 is also asking and req0 was the last one served
   assign w_gnt0 = r0_valid & (~r1_valid | r_last_grant);
   assign w_gnt1 = r1_valid & ~w_gnt0;

`ifdef RAM_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] r_cnt;
   logic          r_timeout_err;

   // mem_ready on the terminal cycle still wins over the watchdog
   assign w_timeout   = (r_state == S_BUSY) && !mem_ready && (r_cnt == '0);
   assign timeout_err = r_timeout_err;
`else
   assign w_timeout = 1'b0;
`endif

   assign w_done = mem_ready | w_timeout;

   assign r0_ready  = r_r0_ready;
   assign r1_ready  = r_r1_ready;
   assign r0_dout   = r_r0_dout;
   assign r1_dout   = r_r1_dout;
   assign mem_valid = r_mem_valid;
   assign mem_wr_rd = r_mem_wr_rd;
   assign mem_addr  = r_mem_addr;
   assign mem_din   = r_mem_din;
   assign grant     = r_grant;

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   // next-state decode
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (r0_valid || r1_valid) w_state_nxt = S_BUSY;
         S_BUSY:  if (w_done) w_state_nxt = S_RESP;
         S_RESP:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // registered outputs: latch the winner's request, return its completion
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_last_grant <= 1'b1;
         r_owner      <= 1'b0;
         r_r0_ready   <= 1'b0;
         r_r1_ready   <= 1'b0;
         r_r0_dout    <= '0;
         r_r1_dout    <= '0;
         r_mem_valid  <= 1'b0;
         r_mem_wr_rd  <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_din    <= '0;
         r_grant      <= 2'b00;
`ifdef RAM_ARB_TIMEOUT_EN
         r_cnt         <= '0;
         r_timeout_err <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_gnt0 || w_gnt1) begin
                  r_owner     <= w_gnt1;
                  r_mem_valid <= 1'b1;
                  r_mem_wr_rd <= w_gnt1 ? r1_wr_rd : r0_wr_rd;
                  r_mem_addr  <= w_gnt1 ? r1_addr  : r0_addr;
                  r_mem_din   <= w_gnt1 ? r1_din   : r0_din;
                  r_grant     <= w_gnt1 ? 2'b10 : 2'b01;
`ifdef RAM_ARB_TIMEOUT_EN
                  r_cnt       <= CW'(TIMEOUT_CYCLES - 1);
`endif
               end
            end
            S_BUSY: begin
               if (w_done) begin
                  r_mem_valid  <= 1'b0;
                  r_last_grant <= r_owner;
                  if (r_owner) begin
                     r_r1_ready <= 1'b1;
                     r_r1_dout  <= w_timeout ? '0 : mem_dout;
                  end else begin
                     r_r0_ready <= 1'b1;
                     r_r0_dout  <= w_timeout ? '0 : mem_dout;
                  end
`ifdef RAM_ARB_TIMEOUT_EN
                  r_timeout_err <= w_timeout;
`endif
               end
`ifdef RAM_ARB_TIMEOUT_EN
               else begin
                  r_cnt <= r_cnt - 1'b1;
               end
`endif
            end
            S_RESP: begin
               r_r0_ready <= 1'b0;
               r_r1_ready <= 1'b0;
               r_grant    <= 2'b00;
`ifdef RAM_ARB_TIMEOUT_EN
               r_timeout_err <= 1'b0;
`endif
            end
            default: ;
         endcase
      end
   end

endmodule
